// File: rtl/demux_stream_1ton.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_1ton
//  Description : Registered 1:N demultiplexer for valid/ready streams.
//                A single producer word is routed to the channel picked by
//                in_sel, or to every channel in broadcast mode. Each output
//                channel owns a one-entry holding register, so a channel can
//                accept a new word in the same cycle its consumer takes the
//                old one (one word per cycle per channel).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    payload width in bits (>= 1)
//    SEL_W     select width; N_OUT = 2**SEL_W channels (>= 1)
//  Ports
//    clk        rising-edge clock
//    rst_n      synchronous reset, active-low
//    en         block enable; 0 = accept nothing, held words still drain
//    in_data    input payload
//    in_sel     destination channel index (ignored when in_bcast = 1)
//    in_bcast   deliver the word to all channels, all-or-nothing
//    in_valid   producer has a word
//    in_ready   word is accepted this cycle (combinational)
//    out_data   channel i payload at [i*DATA_W +: DATA_W], zero when empty
//    out_valid  channel i holds a word
//    out_ready  consumer i takes its word this cycle
//    busy       at least one channel holds a word
// ============================================================================
module demux_stream_1ton #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    localparam int N_OUT = 2 ** SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    busy
);

    // Per-channel state: the valid flag is the whole state machine.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [N_OUT-1:0]  r_vld;
    logic [DATA_W-1:0] r_data [N_OUT];

    logic [N_OUT-1:0]  w_can_acc;
    logic [N_OUT-1:0]  w_target;
    logic              w_xfer;

    // A channel can take a word if it is empty or is being drained right now.
    assign w_can_acc = ~r_vld | out_ready;

    // Broadcast needs every channel free so delivery is never partial.
    // While reset is held nothing is taken, so acceptance is not advertised.
    assign in_ready = rst_n & en &
                      (in_bcast ? (&w_can_acc) : w_can_acc[in_sel]);

    assign w_xfer = in_valid & in_ready;

    assign busy = |r_vld;

    generate
        for (genvar i = 0; i < N_OUT; i++) begin : g_ch
            assign w_target[i] = w_xfer & (in_bcast | (in_sel == SEL_W'(i)));

            // Load has priority over drain so a simultaneous take-and-refill
            // keeps the channel full with the new word.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld[i]  <= ST_EMPTY;
                    r_data[i] <= '0;
                end else if (w_target[i]) begin
                    r_vld[i]  <= ST_FULL;
                    r_data[i] <= in_data;
                end else if ((r_vld[i] == ST_FULL) && out_ready[i]) begin
                    // Stale payload stays in r_data; output masking hides it.
                    r_vld[i]  <= ST_EMPTY;
                end
            end

            assign out_valid[i] = r_vld[i];
            assign out_data[i*DATA_W +: DATA_W] =
                (r_vld[i] == ST_FULL) ? r_data[i] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1ton.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_stream_1ton
//  Description : Directed bench for demux_stream_1ton (DATA_W=8, SEL_W=2).
//                Issued words push hand-written expected payloads into
//                per-channel queues; a monitor pops and compares on every
//                consumer handshake. Direct checks cover reset, stalls,
//                masking and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1ton;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;
    localparam int N_OUT  = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic                    busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] sb_q [N_OUT][$];

    demux_stream_1ton #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel,
                         input logic bc, input logic [7:0] d);
        in_valid = v;
        in_sel   = sel;
        in_bcast = bc;
        in_data  = d;
        #1;
    endtask

    // Monitor: a consumer handshake at the coming edge is decided by the
    // values visible at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_q[i].size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL monitor_ch%0d: unexpected word %h, none expected",
                                 i, out_data[i*DATA_W +: DATA_W]);
                    end else begin
                        chk($sformatf("monitor_ch%0d", i),
                            32'(out_data[i*DATA_W +: DATA_W]),
                            32'(sb_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;

        // ---- 1: reset with a word offered ----
        rst_n = 1'b0; en = 1'b1; out_ready = 4'b0000;
        drive(1'b1, 2'd0, 1'b0, 8'hFF);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_busy",      32'(busy), 32'h0);
        chk("rst_in_ready",  32'(in_ready), 32'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // ---- 2: unicast to channel 2 ----
        drive(1'b1, 2'd2, 1'b0, 8'hA5);
        chk("uni_in_ready", 32'(in_ready), 32'h1);
        sb_q[2].push_back(8'hA5);
        tick();
        in_valid = 1'b0;
        chk("uni_out_valid", 32'(out_valid), 32'h4);
        chk("uni_out_data",  out_data, 32'h00A5_0000);
        chk("uni_busy",      32'(busy), 32'h1);
        drive(1'b1, 2'd2, 1'b0, 8'h5A);
        chk("uni_full_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("uni_full_hold", out_data, 32'h00A5_0000);
        in_valid = 1'b0;
        out_ready = 4'b0100;
        tick();
        chk("uni_drained", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        // ---- 3: back-to-back into channel 1 ----
        out_ready = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd1, 1'b0, seq[k]);
            chk($sformatf("b2b_in_ready_%0d", k), 32'(in_ready), 32'h1);
            sb_q[1].push_back(seq[k]);
            tick();
            chk($sformatf("b2b_slice1_%0d", k), 32'(out_data[15:8]), 32'(seq[k]));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_empty", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        // ---- 4: broadcast blocked by full channel 0 ----
        drive(1'b1, 2'd0, 1'b0, 8'h11);
        sb_q[0].push_back(8'h11);
        tick();
        drive(1'b1, 2'd3, 1'b1, 8'h3C);
        chk("bc_blocked_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("bc_no_partial_valid", 32'(out_valid), 32'h1);
        chk("bc_no_partial_data",  out_data, 32'h0000_0011);
        out_ready = 4'b0001;
        #1;
        chk("bc_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < N_OUT; i++) sb_q[i].push_back(8'h3C);
        tick();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        #1;
        chk("bc_out_valid", 32'(out_valid), 32'hF);
        chk("bc_out_data",  out_data, 32'h3C3C_3C3C);

        // ---- 5: enable low, drains continue ----
        en = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 8'h77);
        chk("en0_in_ready", 32'(in_ready), 32'h0);
        out_ready = 4'b1111;
        tick();
        chk("en0_drained", 32'(out_valid), 32'h0);
        chk("en0_in_ready_still", 32'(in_ready), 32'h0);
        tick();
        chk("en0_no_load", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;
        en = 1'b1;
        #1;
        chk("en1_in_ready", 32'(in_ready), 32'h1);
        sb_q[3].push_back(8'h77);
        tick();
        in_valid = 1'b0;
        chk("en1_out_valid", 32'(out_valid), 32'h8);
        chk("en1_out_data",  out_data, 32'h7700_0000);

        // ---- 6: reset mid-operation ----
        drive(1'b1, 2'd0, 1'b0, 8'h99);
        sb_q[0].push_back(8'h99);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'h9);
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < N_OUT; i++) sb_q[i].delete();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data",  out_data, 32'h0);
        chk("mid_rst_busy",  32'(busy), 32'h0);
        out_ready = 4'b1111;
        tick();
        tick();
        chk("mid_no_stale", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        // recovery: one more word through channel 1
        drive(1'b1, 2'd1, 1'b0, 8'hC3);
        sb_q[1].push_back(8'hC3);
        tick();
        in_valid = 1'b0;
        chk("rec_out_data", out_data, 32'h0000_C300);
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        chk("rec_drained", 32'(out_valid), 32'h0);

        for (int i = 0; i < N_OUT; i++)
            chk($sformatf("sb_empty_ch%0d", i), 32'(sb_q[i].size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
